// File: rtl/skewer_pkg.sv
// ============================================================================
// Module  : skewer_pkg
// Brief   : Shared FSM states and counter sizing for the systolic input skewer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package skewer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STREAM  = 2'd1,
    DRAIN   = 2'd2,
    DONE_ST = 2'd3
  } skew_state_t;

  localparam int c_cnt_w_min = 1;

  // Drain counter width: max(1, clog2(rows)).
  function automatic int skew_cnt_width(input int rows);
    int w;
    w = $clog2(rows);
    return (w < c_cnt_w_min) ? c_cnt_w_min : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/skew_delay_line.sv
// ============================================================================
// Module  : skew_delay_line
// Brief   : Fixed-depth data+valid shift register, one per skewer lane.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module skew_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i]  <= '0;
        r_valid[i] <= 1'b0;
      end
    end else begin
      r_data[0]  <= i_data;
      r_valid[0] <= i_valid;
      for (int i = 1; i < DEPTH; i++) begin
        r_data[i]  <= r_data[i-1];
        r_valid[i] <= r_valid[i-1];
      end
    end
  end

  assign o_data  = r_data[DEPTH-1];
  assign o_valid = r_valid[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/systolic_input_skewer.sv
// ============================================================================
// Module  : systolic_input_skewer
// Brief   : Diagonally skews activation vectors onto the array's left edge.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_input_skewer
  import skewer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ROWS  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  In_Valid,
  output logic                  In_Ready,
  input  logic                  In_Last,
  input  logic [ROWS*WIDTH-1:0] In_Data,
  output logic [ROWS*WIDTH-1:0] Out_Data,
  output logic [ROWS-1:0]       Out_Valid,
  output logic                  Done,
  output logic                  Busy
);

  localparam int                c_cnt_w    = skew_cnt_width(ROWS);
  localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'((ROWS > 1) ? ROWS - 2 : 0);

  skew_state_t        r_state;
  skew_state_t        w_next_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_next_cnt;
  logic               r_done;
  logic               r_busy;
  logic               w_accept;

  assign In_Ready = (r_state == IDLE) || (r_state == STREAM);
  assign w_accept = In_Valid && In_Ready;
  assign Done     = r_done;
  assign Busy     = r_busy;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      // Done trails DONE_ST by one edge so it lines up with the last element leaving.
      r_done  <= (r_state == DONE_ST);
      r_busy  <= (w_next_state == STREAM) || (w_next_state == DRAIN);
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      IDLE, STREAM: begin
        if (w_accept) begin
          if (In_Last) begin
            w_next_cnt = c_cnt_load;
            if (ROWS == 1) begin
              w_next_state = DONE_ST;
            end else begin
              w_next_state = DRAIN;
            end
          end else begin
            w_next_state = STREAM;
          end
        end
      end
      DRAIN: begin
        if (r_cnt == '0) begin
          w_next_state = DONE_ST;
        end else begin
          w_next_cnt = r_cnt - 1'b1;
        end
      end
      DONE_ST: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [WIDTH-1:0] w_head_data;

    // Non-accept cycles push zeros so downstream MACs add nothing.
    assign w_head_data = w_accept ? In_Data[r*WIDTH +: WIDTH] : '0;

    skew_delay_line #(
      .WIDTH (WIDTH),
      .DEPTH (r + 1)
    ) u_delay (
      .CLK     (CLK),
      .RST     (RST),
      .i_data  (w_head_data),
      .i_valid (w_accept),
      .o_data  (Out_Data[r*WIDTH +: WIDTH]),
      .o_valid (Out_Valid[r])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_systolic_input_skewer.sv
// ============================================================================
// Module  : tb_systolic_input_skewer
// Brief   : Table, directed and random checks of the skewer against a history model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_systolic_input_skewer;

  localparam int WIDTH = 8;
  localparam int ROWS  = 4;
  localparam int DW    = ROWS * WIDTH;
  localparam int MAXC  = 2048;

  logic            CLK = 1'b0;
  logic            RST;
  logic            In_Valid, In_Last, In_Ready, Done, Busy;
  logic [DW-1:0]   In_Data, Out_Data;
  logic [ROWS-1:0] Out_Valid;

  logic       s_valid = 1'b0, s_last = 1'b0, s_ready, s_done, s_busy;
  logic [7:0] s_data = 8'h00, s_out_data;
  logic [0:0] s_out_valid;

  always #5 CLK = ~CLK;

  systolic_input_skewer #(.WIDTH(WIDTH), .ROWS(ROWS)) u_dut (
    .CLK(CLK), .RST(RST), .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Last(In_Last),
    .In_Data(In_Data), .Out_Data(Out_Data), .Out_Valid(Out_Valid), .Done(Done), .Busy(Busy)
  );

  systolic_input_skewer #(.WIDTH(8), .ROWS(1)) u_dut1 (
    .CLK(CLK), .RST(RST), .In_Valid(s_valid), .In_Ready(s_ready), .In_Last(s_last),
    .In_Data(s_data), .Out_Data(s_out_data), .Out_Valid(s_out_valid), .Done(s_done), .Busy(s_busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int k = 0;

  // Reference model: what was accepted at each edge, plus the last-accept edge.
  logic          hist_v [MAXC];
  logic [DW-1:0] hist_d [MAXC];
  logic          m_ready = 1'b1;
  logic          m_open  = 1'b0;
  int            m_last_e = -1000;
  int            m_rst_k  = 0;

  logic [DW-1:0]   e_data;
  logic [ROWS-1:0] e_valid;
  logic            e_ready, e_done, e_busy;

  typedef struct packed {
    logic          v;
    logic          l;
    logic [DW-1:0] d;
    logic [DW-1:0] eo;
    logic [ROWS-1:0] ev;
    logic          er;
    logic          ed;
    logic          eb;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, k);
    end
  endtask

  task automatic cycle(input logic v, input logic l, input logic [DW-1:0] d, input logic rn);
    logic acc;
    int   j;
    In_Valid = v;
    In_Last  = l;
    In_Data  = d;
    RST      = rn;
    @(posedge CLK);
    k++;
    if (k >= MAXC) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", k, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    if (!rn) begin
      hist_v[k] = 1'b0;
      hist_d[k] = '0;
      m_last_e  = -1000;
      m_open    = 1'b0;
      m_rst_k   = k;
    end else begin
      acc       = v && m_ready;
      hist_v[k] = acc;
      hist_d[k] = acc ? d : '0;
      if (acc) begin
        if (l) begin
          m_last_e = k;
          m_open   = 1'b0;
        end else begin
          m_open = 1'b1;
        end
      end
    end
    e_data  = '0;
    e_valid = '0;
    for (int r = 0; r < ROWS; r++) begin
      j = k - r;
      if (j > m_rst_k && hist_v[j]) begin
        e_valid[r]               = 1'b1;
        e_data[r*WIDTH +: WIDTH] = hist_d[j][r*WIDTH +: WIDTH];
      end
    end
    e_done  = (k == m_last_e + ROWS);
    e_ready = !(k >= m_last_e && k <= m_last_e + ROWS - 1);
    e_busy  = m_open || (k >= m_last_e && k <= m_last_e + ROWS - 2);
    m_ready = e_ready;
    #1;
    check("out_data",  Out_Data,  e_data);
    check("out_valid", Out_Valid, e_valid);
    check("in_ready",  In_Ready,  e_ready);
    check("done",      Done,      e_done);
    check("busy",      Busy,      e_busy);
  endtask

  initial begin
    for (int i = 0; i < MAXC; i++) begin
      hist_v[i] = 1'b0;
      hist_d[i] = '0;
    end
    tbl[0] = '{1'b1, 1'b1, 32'h04030201, 32'h00000001, 4'b0001, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 32'h0,        32'h00000200, 4'b0010, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 32'h0,        32'h00030000, 4'b0100, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 32'h0,        32'h04000000, 4'b1000, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 32'h0,        32'h0,        4'b0000, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 32'h0,        32'h0,        4'b0000, 1'b1, 1'b0, 1'b0};

    // Reset for two cycles, then release.
    cycle(1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0);
    check("rst_s1_out", {s_out_valid, s_out_data, s_done, s_busy}, 11'h0);
    cycle(1'b0, 1'b0, '0, 1'b1);
    check("rst_ready", In_Ready, 1'b1);

    // Single last vector from a fixed table.
    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i].v, tbl[i].l, tbl[i].d, 1'b1);
      check("tbl_data",  Out_Data,  tbl[i].eo);
      check("tbl_valid", Out_Valid, tbl[i].ev);
      check("tbl_ready", In_Ready,  tbl[i].er);
      check("tbl_done",  Done,      tbl[i].ed);
      check("tbl_busy",  Busy,      tbl[i].eb);
    end

    // Three back-to-back, a bubble, then the last vector.
    cycle(1'b1, 1'b0, 32'h13121110, 1'b1);
    cycle(1'b1, 1'b0, 32'h23222120, 1'b1);
    cycle(1'b1, 1'b0, 32'h33323130, 1'b1);
    cycle(1'b0, 1'b0, 32'hDEADBEEF, 1'b1);
    cycle(1'b1, 1'b1, 32'h53525150, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, '0, 1'b1);

    // Valid held through the lockout: second vector waits until IDLE.
    cycle(1'b1, 1'b1, 32'hA3A2A1A0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 32'hB3B2B1B0, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, '0, 1'b1);

    // Reset in the middle of a drain: everything cleared, no Done.
    cycle(1'b1, 1'b0, 32'hC3C2C1C0, 1'b1);
    cycle(1'b1, 1'b1, 32'hD3D2D1D0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b0);
    check("mid_rst_out", {Out_Valid, Out_Data, Done, Busy}, 38'h0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, '0, 1'b1);

    // Single-row instance.
    s_valid = 1'b1;
    s_last  = 1'b1;
    s_data  = 8'hA5;
    cycle(1'b0, 1'b0, '0, 1'b1);
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 8'h00;
    check("r1_data",  s_out_data,  8'hA5);
    check("r1_valid", s_out_valid, 1'b1);
    check("r1_ready", s_ready,     1'b0);
    check("r1_done0", s_done,      1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1);
    check("r1_data_clr", {s_out_valid, s_out_data}, 9'h0);
    check("r1_done1", s_done,  1'b1);
    check("r1_ready1", s_ready, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);
    check("r1_done_pulse", s_done, 1'b0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 500; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, DW'($urandom),
            $urandom_range(0, 99) != 0);
    end
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, '0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
